// File: rtl/vec_mul_tiled_if.sv
// Handshake bundle for vec_mul_tiled: weight-row load, data chunk in, result out.
interface vec_mul_tiled_if #(
   parameter int DATA_BW        = 8,
   parameter int WEIGHT_BW      = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int MATRIX_SIZE    = 8
);
   logic                                  weight_reload;
   logic                                  w_valid;
   logic                                  w_ready;
   logic [WEIGHT_BW*MATRIX_SIZE-1:0]      w_row;
   logic                                  in_valid;
   logic                                  in_ready;
   logic [DATA_BW*MATRIX_SIZE-1:0]        data_in;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] data_out;
   logic                                  out_sat;

   modport master (
      output weight_reload, w_valid, w_row, in_valid, data_in, out_ready,
      input  w_ready, in_ready, out_valid, data_out, out_sat
   );

   modport slave (
      input  weight_reload, w_valid, w_row, in_valid, data_in, out_ready,
      output w_ready, in_ready, out_valid, data_out, out_sat
   );
endinterface

// File: rtl/vec_mul_tiled.sv
// Tiled vector x matrix multiplier: a K-element signed vector arrives as
// K_TILES chunks of MATRIX_SIZE elements and is multiplied against a stored
// K x MATRIX_SIZE weight matrix, producing MATRIX_SIZE saturated lanes.
module vec_mul_tiled #(
   parameter int DATA_BW        = 8,
   parameter int WEIGHT_BW      = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int MATRIX_SIZE    = 8,
   parameter int K_TILES        = 2
) (
   input  logic           clk,
   input  logic           rstn,
   vec_mul_tiled_if.slave bus
);
   localparam int unsigned N      = MATRIX_SIZE;
   localparam int unsigned K      = K_TILES * MATRIX_SIZE;
   localparam int unsigned KW     = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned CW     = (K_TILES > 1) ? $clog2(K_TILES) : 1;
   localparam int unsigned ACC_BW = DATA_BW + WEIGHT_BW + $clog2(K);
   localparam int unsigned EXT_BW = (ACC_BW > PARTIAL_SUM_BW) ? ACC_BW : PARTIAL_SUM_BW;

   localparam logic signed [EXT_BW-1:0] SAT_MAX =
      {{(EXT_BW-PARTIAL_SUM_BW+1){1'b0}}, {(PARTIAL_SUM_BW-1){1'b1}}};
   localparam logic signed [EXT_BW-1:0] SAT_MIN =
      {{(EXT_BW-PARTIAL_SUM_BW+1){1'b1}}, {(PARTIAL_SUM_BW-1){1'b0}}};

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]                      state;
   logic [KW-1:0]                   row_cnt;
   logic [CW-1:0]                   chunk_cnt;
   logic [WEIGHT_BW*N-1:0]          w_mem [K];
   logic signed [ACC_BW-1:0]        acc [N];
   logic signed [ACC_BW-1:0]        acc_next [N];
   logic                            out_valid_q;
   logic                            out_sat_q;
   logic [PARTIAL_SUM_BW*N-1:0]     data_out_q;
   logic [PARTIAL_SUM_BW*N-1:0]     sat_packed;
   logic                            sat_any;

   logic signed [DATA_BW-1:0]       xe;
   logic signed [WEIGHT_BW-1:0]     we;
   logic signed [DATA_BW+WEIGHT_BW-1:0] prod;
   logic signed [ACC_BW-1:0]        lane;
   logic signed [EXT_BW-1:0]        ext;
   logic [KW-1:0]                   widx;

   logic reload_go;
   logic w_fire;
   logic in_fire;
   logic last_chunk;

   // A reload is only honoured while no result is waiting to be consumed.
   assign reload_go  = bus.weight_reload && !out_valid_q;
   assign w_fire     = (state == ST_LOAD) && bus.w_valid;
   assign in_fire    = (state == ST_RUN) && !out_valid_q && bus.in_valid;
   assign last_chunk = (chunk_cnt == CW'(K_TILES - 1));

   assign bus.w_ready   = (state == ST_LOAD);
   assign bus.in_ready  = (state == ST_RUN) && !out_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_out_q;
   assign bus.out_sat   = out_sat_q;

   // Per-lane chunk dot product added to the running sum, then clipped for output.
   always_comb begin
      xe         = '0;
      we         = '0;
      prod       = '0;
      lane       = '0;
      ext        = '0;
      widx       = '0;
      sat_packed = '0;
      sat_any    = 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
         lane = acc[c];
         for (int unsigned e = 0; e < N; e++) begin
            widx = KW'(chunk_cnt * N + e);
            xe   = bus.data_in[(N-1-e)*DATA_BW +: DATA_BW];
            we   = w_mem[widx][(N-1-c)*WEIGHT_BW +: WEIGHT_BW];
            prod = xe * we;
            lane = lane + ACC_BW'(prod);
         end
         acc_next[c] = lane;
         ext = EXT_BW'(lane);
         if (ext > SAT_MAX) begin
            sat_packed[(N-1-c)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(SAT_MAX);
            sat_any = 1'b1;
         end else if (ext < SAT_MIN) begin
            sat_packed[(N-1-c)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(SAT_MIN);
            sat_any = 1'b1;
         end else begin
            sat_packed[(N-1-c)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(ext);
         end
      end
   end

   // Control FSM, row counter and weight store writes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_EMPTY;
         row_cnt <= '0;
         for (int unsigned k = 0; k < K; k++) w_mem[k] <= '0;
      end else if (reload_go) begin
         state   <= ST_LOAD;
         row_cnt <= '0;
      end else if (w_fire) begin
         w_mem[row_cnt] <= bus.w_row;
         if (row_cnt == KW'(K - 1)) begin
            state   <= ST_RUN;
            row_cnt <= '0;
         end else begin
            row_cnt <= row_cnt + KW'(1);
         end
      end
   end

   // Chunk accumulation, result capture and output handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chunk_cnt   <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         data_out_q  <= '0;
         for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         if (reload_go) begin
            // Any partially accumulated vector is dropped with the old weights.
            chunk_cnt <= '0;
            for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
         end else if (in_fire) begin
            if (last_chunk) begin
               data_out_q  <= sat_packed;
               out_sat_q   <= sat_any;
               out_valid_q <= 1'b1;
               chunk_cnt   <= '0;
               for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
            end else begin
               chunk_cnt <= chunk_cnt + CW'(1);
               for (int unsigned c = 0; c < N; c++) acc[c] <= acc_next[c];
            end
         end
      end
   end
endmodule

// File: tb/tb_vec_mul_tiled.sv
// Directed bench for vec_mul_tiled: default instance (20-bit lanes) and a
// 16-bit-lane instance driven with identical stimulus.
module tb_vec_mul_tiled;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic weight_reload = 1'b0;
   logic w_valid       = 1'b0;
   logic in_valid      = 1'b0;
   logic out_ready     = 1'b0;
   logic [63:0] w_row   = '0;
   logic [63:0] data_in = '0;

   int tests = 0;
   int fails = 0;
   logic [63:0]  wmat [16];
   logic [63:0]  x0, x1, r;
   logic [159:0] exp_v;
   int first, second;

   vec_mul_tiled_if ifa ();
   vec_mul_tiled_if #(.PARTIAL_SUM_BW(16)) ifb ();

   assign ifa.weight_reload = weight_reload;
   assign ifa.w_valid       = w_valid;
   assign ifa.w_row         = w_row;
   assign ifa.in_valid      = in_valid;
   assign ifa.data_in       = data_in;
   assign ifa.out_ready     = out_ready;
   assign ifb.weight_reload = weight_reload;
   assign ifb.w_valid       = w_valid;
   assign ifb.w_row         = w_row;
   assign ifb.in_valid      = in_valid;
   assign ifb.data_in       = data_in;
   assign ifb.out_ready     = out_ready;

   vec_mul_tiled u_dut (.clk(clk), .rstn(rstn), .bus(ifa));
   vec_mul_tiled #(.PARTIAL_SUM_BW(16)) u_dut16 (.clk(clk), .rstn(rstn), .bus(ifb));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] fill8(input logic [7:0] v);
      return {8{v}};
   endfunction

   task automatic set_w_all(input logic [7:0] v);
      for (int k = 0; k < 16; k++) wmat[k] = fill8(v);
   endtask

   task automatic load_w();
      weight_reload = 1'b1;
      step();
      weight_reload = 1'b0;
      chk("w_ready_in_load", ifa.w_ready, 1);
      chk("in_ready_in_load", ifa.in_ready, 0);
      for (int k = 0; k < 16; k++) begin
         w_row   = wmat[k];
         w_valid = 1'b1;
         step();
      end
      w_valid = 1'b0;
      chk("w_ready_after_load", ifa.w_ready, 0);
   endtask

   task automatic send_chunk(input logic [63:0] x);
      int n;
      data_in  = x;
      in_valid = 1'b1;
      n = 0;
      while (!ifa.in_ready && n < 20) begin
         step();
         n++;
      end
      chk("in_ready_wait", ifa.in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [63:0] a, input logic [63:0] b);
      send_chunk(a);
      chk("out_valid_mid_vector", ifa.out_valid, 0);
      send_chunk(b);
      chk("out_valid_latency", ifa.out_valid, 1);
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_clear", ifa.out_valid, 0);
   endtask

   initial begin
      // Reset state and idle behaviour without any weights loaded.
      step(); step(); step();
      chk("rst_in_ready", ifa.in_ready, 0);
      chk("rst_w_ready", ifa.w_ready, 0);
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_data_out", ifa.data_out, 0);
      chk("rst_out_sat", ifa.out_sat, 0);
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = i[0];
         data_in  = fill8(8'd1);
         step();
         chk("idle_in_ready", ifa.in_ready, 0);
         chk("idle_out_valid", ifa.out_valid, 0);
      end
      in_valid = 1'b0;
      chk("idle_w_ready", ifa.w_ready, 0);

      // All-ones weights, x all 2: each lane 16*2 = 32.
      set_w_all(8'd1);
      load_w();
      chk("run_in_ready", ifa.in_ready, 1);
      send_vec(fill8(8'd2), fill8(8'd2));
      chk("ones_data", ifa.data_out, {8{20'd32}});
      chk("ones_sat", ifa.out_sat, 0);
      chk("ones_data16", ifb.data_out, {8{16'd32}});

      // Back-pressure: result held, chunks refused, reload ignored.
      in_valid = 1'b1;
      data_in  = fill8(8'd5);
      for (int i = 0; i < 5; i++) begin
         weight_reload = (i == 2);
         step();
         weight_reload = 1'b0;
         chk("stall_out_valid", ifa.out_valid, 1);
         chk("stall_data", ifa.data_out, {8{20'd32}});
         chk("stall_in_ready", ifa.in_ready, 0);
         chk("stall_w_ready", ifa.w_ready, 0);
      end
      in_valid = 1'b0;
      take_out();
      chk("release_in_ready", ifa.in_ready, 1);
      send_vec(fill8(8'd2), fill8(8'd2));
      chk("after_stall_data", ifa.data_out, {8{20'd32}});
      take_out();

      // Identity-like weights, x[k] = k-8: y[c] = c-8.
      for (int k = 0; k < 16; k++) begin
         r = '0;
         if (k < 8) r[(7-k)*8 +: 8] = 8'd1;
         wmat[k] = r;
      end
      for (int e = 0; e < 8; e++) begin
         x0[(7-e)*8 +: 8] = 8'(e - 8);
         x1[(7-e)*8 +: 8] = 8'(e);
      end
      for (int c = 0; c < 8; c++) exp_v[(7-c)*20 +: 20] = 20'(c - 8);
      load_w();
      send_vec(x0, x1);
      chk("ident_data", ifa.data_out, exp_v);
      chk("ident_sat", ifa.out_sat, 0);
      take_out();

      // Saturation: 127 * -128 * 16 = -260096; -128 * -128 * 16 = 262144.
      set_w_all(8'd127);
      load_w();
      send_vec(fill8(8'h80), fill8(8'h80));
      chk("satneg_data16", ifb.data_out, {8{16'h8000}});
      chk("satneg_sat16", ifb.out_sat, 1);
      chk("satneg_data20", ifa.data_out, {8{20'hC0800}});
      chk("satneg_sat20", ifa.out_sat, 0);
      take_out();
      set_w_all(8'h80);
      load_w();
      send_vec(fill8(8'h80), fill8(8'h80));
      chk("satpos_data16", ifb.data_out, {8{16'h7FFF}});
      chk("satpos_sat16", ifb.out_sat, 1);
      chk("satpos_data20", ifa.data_out, {8{20'h40000}});
      chk("satpos_sat20", ifa.out_sat, 0);
      take_out();

      // Partial vector discarded by a reload; new weights all 3, x all 1 -> 48.
      set_w_all(8'd1);
      load_w();
      send_chunk(fill8(8'd7));
      chk("partial_out_valid", ifa.out_valid, 0);
      set_w_all(8'd3);
      load_w();
      send_vec(fill8(8'd1), fill8(8'd1));
      chk("discard_data", ifa.data_out, {8{20'd48}});
      chk("discard_data16", ifb.data_out, {8{16'd48}});
      take_out();

      // Sustained traffic with out_ready held high: one result every 3 cycles.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = fill8(8'd1);
      first  = -1;
      second = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ifa.out_valid) begin
            if (first < 0) begin
               first = i;
               chk("tput_data", ifa.data_out, {8{20'd48}});
            end else if (second < 0) begin
               second = i;
            end
         end
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("tput_period", 160'(second - first), 3);

      // Reset in the middle of a vector abandons everything.
      send_chunk(fill8(8'd1));
      rstn = 1'b0;
      #1;
      chk("midrst_in_ready", ifa.in_ready, 0);
      chk("midrst_w_ready", ifa.w_ready, 0);
      chk("midrst_out_valid", ifa.out_valid, 0);
      chk("midrst_data", ifa.data_out, 0);
      step(); step();
      rstn = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("postrst_in_ready", ifa.in_ready, 0);
         chk("postrst_out_valid", ifa.out_valid, 0);
      end
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
